// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcode constants, immediate formats and the default datapath width.
// Used by the decode stage and the execute-stage ALU.
package riscv_pkg;

   localparam int WIDTH_DEF = 32;

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   typedef enum logic [2:0] {
      FMT_I,
      FMT_S,
      FMT_B,
      FMT_J,
      FMT_U,
      FMT_NONE
   } imm_fmt_t;

   function automatic imm_fmt_t imm_fmt_of(input logic [6:0] opcode);
      case (opcode)
         OPC_OP_IMM, OPC_LOAD, OPC_JALR: imm_fmt_of = FMT_I;
         OPC_STORE:                      imm_fmt_of = FMT_S;
         OPC_BRANCH:                     imm_fmt_of = FMT_B;
         OPC_JAL:                        imm_fmt_of = FMT_J;
         OPC_LUI, OPC_AUIPC:             imm_fmt_of = FMT_U;
         default:                        imm_fmt_of = FMT_NONE;
      endcase
   endfunction

endpackage

// File: rtl/reg_file.sv
// Integer register file: two combinational read ports with write-through bypass,
// one synchronous write port, x0 reads as zero.
import riscv_pkg::*;

module reg_file #(
   parameter int WIDTH = WIDTH_DEF,
   parameter int NREGS = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [4:0]            waddr,
   input  logic [WIDTH-1:0]      wdata,
   input  logic [1:0][4:0]       raddr,
   output logic [1:0][WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] regs [NREGS];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (we && waddr != 5'd0) begin
         regs[waddr] <= wdata;
      end
   end

   // A write landing in the same cycle as a read is forwarded straight to the reader.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_rd
         assign rdata[gi] = (raddr[gi] == 5'd0)              ? '0    :
                            (we && waddr == raddr[gi])       ? wdata :
                                                               regs[raddr[gi]];
      end
   endgenerate

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: register-file reads, operand selection and immediate generation
// into a registered execute-stage interface with stall/flush control.
import riscv_pkg::*;

module decode_stage #(
   parameter int WIDTH = WIDTH_DEF,
   parameter int NREGS = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             if_valid,
   input  logic [31:0]      if_instr,
   input  logic [WIDTH-1:0] if_pc,
   output logic             if_ready,
   input  logic             stall,
   input  logic             flush,
   input  logic             wb_we,
   input  logic [4:0]       wb_rd,
   input  logic [WIDTH-1:0] wb_data,
   output logic             ex_valid,
   output logic [6:0]       ex_opcode,
   output logic [2:0]       ex_funct3,
   output logic [6:0]       ex_funct7,
   output logic [WIDTH-1:0] ex_op_a,
   output logic [WIDTH-1:0] ex_op_b,
   output logic [WIDTH-1:0] ex_imm,
   output logic [WIDTH-1:0] ex_store_data,
   output logic [4:0]       ex_rd,
   output logic             ex_reg_write,
   output logic [WIDTH-1:0] ex_pc,
   output logic             ex_illegal
);

   localparam logic [WIDTH-1:0] LINK_OFFSET = WIDTH'(4);

   logic [31:0]            held_instr_reg;
   logic [WIDTH-1:0]       held_pc_reg;
   logic [31:0]            sel_instr;
   logic [WIDTH-1:0]       sel_pc;
   logic [1:0][4:0]        raddr;
   logic [1:0][WIDTH-1:0]  rdata;
   logic [6:0]             opcode;
   imm_fmt_t               fmt;
   logic [WIDTH-1:0]       imm_next;
   logic [WIDTH-1:0]       op_a_next;
   logic [WIDTH-1:0]       op_b_next;
   logic                   reg_write_next;
   logic                   illegal_next;

   assign if_ready = !stall;

   // While stalled, the held instruction is re-decoded so operands pick up late writebacks.
   assign sel_instr = stall ? held_instr_reg : if_instr;
   assign sel_pc    = stall ? held_pc_reg    : if_pc;
   assign raddr     = {sel_instr[24:20], sel_instr[19:15]};
   assign opcode    = sel_instr[6:0];
   assign fmt       = imm_fmt_of(opcode);

   reg_file #(.WIDTH(WIDTH), .NREGS(NREGS)) u_reg_file (
      .clk   (clk),
      .rst   (rst),
      .we    (wb_we),
      .waddr (wb_rd),
      .wdata (wb_data),
      .raddr (raddr),
      .rdata (rdata)
   );

   always_comb begin
      case (fmt)
         FMT_I:   imm_next = {{(WIDTH-11){sel_instr[31]}}, sel_instr[30:20]};
         FMT_S:   imm_next = {{(WIDTH-11){sel_instr[31]}}, sel_instr[30:25], sel_instr[11:7]};
         FMT_B:   imm_next = {{(WIDTH-12){sel_instr[31]}}, sel_instr[7], sel_instr[30:25],
                              sel_instr[11:8], 1'b0};
         FMT_J:   imm_next = {{(WIDTH-20){sel_instr[31]}}, sel_instr[19:12], sel_instr[20],
                              sel_instr[30:21], 1'b0};
         FMT_U:   imm_next = {{(WIDTH-31){sel_instr[31]}}, sel_instr[30:12], 12'b0};
         default: imm_next = '0;
      endcase
   end

   always_comb begin
      op_a_next      = '0;
      op_b_next      = '0;
      reg_write_next = 1'b0;
      illegal_next   = 1'b0;
      case (opcode)
         OPC_OP_IMM, OPC_LOAD: begin
            op_a_next      = rdata[0];
            op_b_next      = imm_next;
            reg_write_next = 1'b1;
         end
         OPC_OP: begin
            op_a_next      = rdata[0];
            op_b_next      = rdata[1];
            reg_write_next = 1'b1;
         end
         OPC_BRANCH: begin
            op_a_next = rdata[0];
            op_b_next = rdata[1];
         end
         OPC_STORE: begin
            op_a_next = rdata[0];
            op_b_next = imm_next;
         end
         OPC_JAL, OPC_JALR: begin
            op_a_next      = sel_pc;
            op_b_next      = LINK_OFFSET;
            reg_write_next = 1'b1;
         end
         OPC_LUI: begin
            op_b_next      = imm_next;
            reg_write_next = 1'b1;
         end
         OPC_AUIPC: begin
            op_a_next      = sel_pc;
            op_b_next      = imm_next;
            reg_write_next = 1'b1;
         end
         default: illegal_next = 1'b1;
      endcase
      if (sel_instr[11:7] == 5'd0) begin
         reg_write_next = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         held_instr_reg <= '0;
         held_pc_reg    <= '0;
         ex_valid       <= 1'b0;
         ex_opcode      <= '0;
         ex_funct3      <= '0;
         ex_funct7      <= '0;
         ex_op_a        <= '0;
         ex_op_b        <= '0;
         ex_imm         <= '0;
         ex_store_data  <= '0;
         ex_rd          <= '0;
         ex_reg_write   <= 1'b0;
         ex_pc          <= '0;
         ex_illegal     <= 1'b0;
      end else if (stall) begin
         ex_op_a       <= op_a_next;
         ex_op_b       <= op_b_next;
         ex_store_data <= rdata[1];
      end else begin
         held_instr_reg <= if_instr;
         held_pc_reg    <= if_pc;
         ex_valid       <= if_valid;
         ex_opcode      <= opcode;
         ex_funct3      <= sel_instr[14:12];
         ex_funct7      <= sel_instr[31:25];
         ex_op_a        <= op_a_next;
         ex_op_b        <= op_b_next;
         ex_imm         <= imm_next;
         ex_store_data  <= rdata[1];
         ex_rd          <= sel_instr[11:7];
         ex_reg_write   <= if_valid && reg_write_next;
         ex_pc          <= sel_pc;
         ex_illegal     <= illegal_next;
      end
   end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction-decode pipeline stage sitting between instruction fetch and the execute-stage ALU. Holds the 32-entry integer register file, and decodes each fetched RV32I instruction into the opcode, funct3, funct7 and operand pair the ALU consumes. It also produces the immediate, the store data and the writeback control. It is the producer end of the ALU operand interface: results are registered, with stall/flush control and a writeback port feeding the register file.

## Interface
- `WIDTH`, 32, datapath and register width
- `NREGS`, 32, architectural registers; x0 is hardwired to zero
- `clk` input 1: the single clock
- `rst` input 1: reset, synchronous, active-high
- `if_valid` input 1: fetch presents a valid instruction
- `if_instr` input 32: instruction word
- `if_pc` input WIDTH: PC of `if_instr`
- `if_ready` output 1: equals `!stall`; fetch advances only when `if_valid && if_ready`
- `stall` input 1: hold the current stage contents
- `flush` input 1: kill the current and incoming instruction
- `wb_we` input 1: register-file write enable
- `wb_rd` input 5: write address
- `wb_data` input WIDTH: write data
- `ex_valid` output 1: outputs below carry a live instruction
- `ex_opcode` output 7: instruction bits [6:0]
- `ex_funct3` output 3: instruction bits [14:12]
- `ex_funct7` output 7: instruction bits [31:25]
- `ex_op_a` output WIDTH: ALU operand 1
- `ex_op_b` output WIDTH: ALU operand 2
- `ex_imm` output WIDTH: sign-extended immediate, used for branch/jump targets
- `ex_store_data` output WIDTH: rs2 value
- `ex_rd` output 5: destination register
- `ex_reg_write` output 1: instruction writes rd, and rd ≠ 0
- `ex_pc` output WIDTH: PC of the instruction
- `ex_illegal` output 1: opcode not in the supported set

## Operation
- Supported opcodes: OP-IMM 0010011, OP 0110011, STORE 0100011, LOAD 0000011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
- Operand selection:
  - OP-IMM and LOAD: a = rs1, b = I-imm. For shifts, b[4:0] carries shamt, since I-imm already equals shamt.
  - OP and BRANCH: a = rs1, b = rs2.
  - STORE: a = rs1, b = S-imm.
  - JAL and JALR: a = pc, b = 4, so the ALU produces the link value.
  - LUI: a = 0, b = U-imm.
  - AUIPC: a = pc, b = U-imm.
- ex_imm by format:
  - I-imm for OP-IMM, LOAD and JALR.
  - S-imm for STORE.
  - B-imm for BRANCH.
  - J-imm for JAL.
  - U-imm for LUI and AUIPC.
- All immediates are sign-extended from instruction bit 31. U-imm is `{instr[31:12], 12'b0}`.
- ex_reg_write is 1 for OP-IMM, OP, LOAD, JAL, JALR, LUI and AUIPC when rd ≠ 0, and 0 otherwise.
- Illegal opcode: ex_illegal = 1, ex_reg_write = 0, operands = 0, and the opcode is passed through unchanged.
- Register file:
  - Writes occur when `wb_we && wb_rd != 0`.
  - Reads of x0 return 0.
  - Same-cycle write/read of a register returns `wb_data` (write-through bypass).
- The stage keeps an internal copy of the held instruction and PC.
- While stalled, the output register reloads from the held copy every cycle, with fresh register-file reads including bypass, so a writeback that lands during a stall is observed.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N appears on the ex_* outputs after edge N.
- Precedence per edge: rst, then flush, then stall, then normal load.
- rst: ex_valid = 0, every ex_* output = 0, held instruction = 0, all registers = 0. Reset mid-stall or mid-flush yields the same result.
- flush: ex_valid = 0 and ex_reg_write = 0 on the next cycle. The held copy is cleared and the incoming fetch is discarded, even if stall is also asserted.
- stall: ex_valid and the instruction fields stay unchanged, operands are refreshed, and if_ready = 0.
- Normal load: ex_valid ← if_valid. A bubble (if_valid = 0) forces ex_reg_write = 0.
- A writeback to rd in the same cycle that rd is read by the incoming instruction is visible at ex_op_a/b one cycle later.

## Structure
- Shared package `riscv_pkg` holds:
  - The opcode constants.
  - An immediate-format enum (I/S/B/J/U/NONE).
  - The WIDTH default.
  - The ALU module uses the same opcode constants.
- Sub-module `reg_file`: NREGS×WIDTH, two combinational read ports with write bypass, one synchronous write port, synchronous reset clear, x0 forced to 0.
- The decode and immediate-generation logic stays combinational inside decode_stage.

## Test plan
- Accept `addi x5, x0, -3` (0xFFD00293) at pc 0x40 → next cycle:
  - ex_op_a = 0, ex_op_b = 0xFFFFFFFD, ex_rd = 5, ex_reg_write = 1.
- Write x6 = 0x1234 via wb in the same cycle as `add x7, x6, x6` is accepted → ex_op_a = ex_op_b = 0x1234 (bypass).
- `sw x2, -4(x1)` with x1 = 0x100, x2 = 0xAB → ex_op_a = 0x100, ex_op_b = 0xFFFFFFFC, ex_store_data = 0xAB, ex_reg_write = 0.
- Each opcode checked at the ex_* outputs:
  - `jal x1, +8` at pc 0x80: ex_op_a = 0x80, ex_op_b = 4, ex_imm = 8.
  - `lui x3, 0x12345`: ex_op_b = 0x12345000.
  - `auipc`: ex_op_a = pc.
- Stall held 3 cycles while wb writes rs1 = 0x55 → ex_op_a becomes 0x55 and ex_valid stays 1. Then assert flush together with stall → ex_valid = 0 next cycle.
- Illegal opcode 0x0000007F → ex_illegal = 1, ex_reg_write = 0. Write to x0 with data 0xFFFF, then read x0 → 0. rst pulse mid-stream → all outputs 0 next cycle.
